// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: two-requester round-robin arbiter for a single VRAM
// write port, with an optional frame-clear fill engine.
//
// Optional feature macro: VRAM_ARB_CLEAR_EN (compiles in the CLEAR state,
// fill counter and clr_* behaviour; without it clr_busy is tied to 0).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   clk_en                clock enable; all state advances only when 1
//   reqN_valid/adr/dat    write request from requester N (N = 0, 1)
//   reqN_ready            combinational grant, accepted on the same edge
//   clr_start, clr_dat    start pulse and fill value for a frame clear
//   clr_busy              clear in progress
//   vram_we/adr_w/dat_w   registered VRAM write port, latency 1

module vram_write_arbiter #(
   parameter int unsigned MAW         = 19,
   parameter int unsigned MDW         = 8,
   parameter int unsigned FRAME_WORDS = 307200
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clk_en,
   input  logic           req0_valid,
   input  logic [MAW-1:0] req0_adr,
   input  logic [MDW-1:0] req0_dat,
   output logic           req0_ready,
   input  logic           req1_valid,
   input  logic [MAW-1:0] req1_adr,
   input  logic [MDW-1:0] req1_dat,
   output logic           req1_ready,
   input  logic           clr_start,
   input  logic [MDW-1:0] clr_dat,
   output logic           clr_busy,
   output logic           vram_we,
   output logic [MAW-1:0] vram_adr_w,
   output logic [MDW-1:0] vram_dat_w
);

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic           ptr_q, ptr_d;
   logic           vram_we_q, vram_we_d;
   logic [MAW-1:0] vram_adr_q, vram_adr_d;
   logic [MDW-1:0] vram_dat_q, vram_dat_d;
   logic           gnt0, gnt1, clr_go;

`ifdef VRAM_ARB_CLEAR_EN
   localparam logic [MAW-1:0] LAST_ADR = MAW'(FRAME_WORDS - 1);

   logic [MAW-1:0] cnt_q, cnt_d;
   logic [MDW-1:0] fill_q, fill_d;
   logic           clr_busy_q, clr_busy_d;
`else
   logic unused_clr;
   assign unused_clr = ^{clr_start, clr_dat};
`endif

   // Grant decode: clear start beats any request; preferred requester wins ties.
   always_comb begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      clr_go = 1'b0;
      if (!rst && clk_en && state_q == ST_ARB) begin
`ifdef VRAM_ARB_CLEAR_EN
         clr_go = clr_start;
`endif
         if (!clr_go) begin
            if (req0_valid && (ptr_q == 1'b0 || !req1_valid)) begin
               gnt0 = 1'b1;
            end else if (req1_valid) begin
               gnt1 = 1'b1;
            end
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Next-state and VRAM port update; everything holds while clk_en=0.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      vram_we_d  = vram_we_q;
      vram_adr_d = vram_adr_q;
      vram_dat_d = vram_dat_q;
`ifdef VRAM_ARB_CLEAR_EN
      cnt_d      = cnt_q;
      fill_d     = fill_q;
      clr_busy_d = clr_busy_q;
`endif
      if (clk_en) begin
         vram_we_d = 1'b0;
         if (gnt0) begin
            vram_we_d  = 1'b1;
            vram_adr_d = req0_adr;
            vram_dat_d = req0_dat;
            ptr_d      = 1'b1;
         end else if (gnt1) begin
            vram_we_d  = 1'b1;
            vram_adr_d = req1_adr;
            vram_dat_d = req1_dat;
            ptr_d      = 1'b0;
         end
`ifdef VRAM_ARB_CLEAR_EN
         if (clr_go) begin
            fill_d     = clr_dat;
            cnt_d      = '0;
            state_d    = ST_CLEAR;
            clr_busy_d = 1'b1;
         end
         // Fill engine: one word per enabled cycle, leave after the last address.
         if (state_q == ST_CLEAR) begin
            vram_we_d  = 1'b1;
            vram_adr_d = cnt_q;
            vram_dat_d = fill_q;
            cnt_d      = cnt_q + MAW'(1);
            if (cnt_q == LAST_ADR) begin
               state_d    = ST_ARB;
               clr_busy_d = 1'b0;
            end
         end
`endif
      end
   end

   // State registers; reset takes effect regardless of clk_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_ARB;
         ptr_q      <= 1'b0;
         vram_we_q  <= 1'b0;
         vram_adr_q <= '0;
         vram_dat_q <= '0;
`ifdef VRAM_ARB_CLEAR_EN
         cnt_q      <= '0;
         fill_q     <= '0;
         clr_busy_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         vram_we_q  <= vram_we_d;
         vram_adr_q <= vram_adr_d;
         vram_dat_q <= vram_dat_d;
`ifdef VRAM_ARB_CLEAR_EN
         cnt_q      <= cnt_d;
         fill_q     <= fill_d;
         clr_busy_q <= clr_busy_d;
`endif
      end
   end

   assign vram_we    = vram_we_q;
   assign vram_adr_w = vram_adr_q;
   assign vram_dat_w = vram_dat_q;

`ifdef VRAM_ARB_CLEAR_EN
   assign clr_busy = clr_busy_q;
`else
   assign clr_busy = 1'b0;
`endif

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Testbench for vram_write_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level reference model (preferred
// requester bit, queue of outstanding fill writes, expected VRAM port value).

module tb_vram_write_arbiter;

   localparam int unsigned MAW = 12;
   localparam int unsigned MDW = 8;
   localparam int unsigned FW  = 16;

`ifdef VRAM_ARB_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst, clk_en;
   logic           v0, v1, r0, r1;
   logic [MAW-1:0] a0, a1;
   logic [MDW-1:0] d0, d1;
   logic           clr_start, clr_busy;
   logic [MDW-1:0] clr_dat;
   logic           vram_we;
   logic [MAW-1:0] vram_adr_w;
   logic [MDW-1:0] vram_dat_w;

   always #5 clk = ~clk;

   vram_write_arbiter #(.MAW(MAW), .MDW(MDW), .FRAME_WORDS(FW)) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .req0_valid (v0),
      .req0_adr   (a0),
      .req0_dat   (d0),
      .req0_ready (r0),
      .req1_valid (v1),
      .req1_adr   (a1),
      .req1_dat   (d1),
      .req1_ready (r1),
      .clr_start  (clr_start),
      .clr_dat    (clr_dat),
      .clr_busy   (clr_busy),
      .vram_we    (vram_we),
      .vram_adr_w (vram_adr_w),
      .vram_dat_w (vram_dat_w)
   );

   typedef struct packed {
      logic [MAW-1:0] adr;
      logic [MDW-1:0] dat;
   } wr_t;

   int             vectors     = 0;
   int             miscompares = 0;
   wr_t            fill_fifo[$];
   bit             m_pref;
   logic           m_we;
   logic [MAW-1:0] m_adr;
   logic [MDW-1:0] m_dat;
   int             fill_writes;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check combinational readies, take the edge, advance the model,
   // then check the registered VRAM port and busy flag.
   task automatic cycle();
      int  g;
      bool_blk: begin end
      g = -1;
      if (!rst && clk_en && fill_fifo.size() == 0 && !(CLR_EN && clr_start)) begin
         if (v0 && v1)  g = int'(m_pref);
         else if (v0)   g = 0;
         else if (v1)   g = 1;
      end
      #1;
      chk("req0_ready", 32'(r0), 32'(g == 0));
      chk("req1_ready", 32'(r1), 32'(g == 1));
      @(posedge clk);
      if (rst) begin
         m_pref = 1'b0;
         fill_fifo.delete();
         m_we  = 1'b0;
         m_adr = '0;
         m_dat = '0;
      end else if (clk_en) begin
         if (fill_fifo.size() != 0) begin
            wr_t w;
            w     = fill_fifo.pop_front();
            m_we  = 1'b1;
            m_adr = w.adr;
            m_dat = w.dat;
            fill_writes++;
         end else if (CLR_EN && clr_start) begin
            for (int i = 0; i < int'(FW); i++) fill_fifo.push_back({MAW'(i), clr_dat});
            m_we = 1'b0;
         end else if (g == 0) begin
            m_we = 1'b1; m_adr = a0; m_dat = d0; m_pref = 1'b1;
         end else if (g == 1) begin
            m_we = 1'b1; m_adr = a1; m_dat = d1; m_pref = 1'b0;
         end else begin
            m_we = 1'b0;
         end
      end
      #1;
      chk("vram_we",    32'(vram_we),    32'(m_we));
      chk("vram_adr_w", 32'(vram_adr_w), 32'(m_adr));
      chk("vram_dat_w", 32'(vram_dat_w), 32'(m_dat));
      chk("clr_busy",   32'(clr_busy),   32'(fill_fifo.size() != 0));
   endtask

   initial begin
      rst = 1'b1; clk_en = 1'b1; clr_start = 1'b0; clr_dat = '0;
      v0 = 1'b1; a0 = 12'h0AA; d0 = 8'h55;
      v1 = 1'b1; a1 = 12'h0BB; d1 = 8'h66;
      m_pref = 1'b0; m_we = 1'b0; m_adr = '0; m_dat = '0; fill_writes = 0;

      // Reset: readies stay low even with valid requests, outputs clear.
      cycle();
      cycle();
      rst = 1'b0;

      // Single requester: same-cycle ready, write appears after one edge.
      v0 = 1'b1; a0 = 12'd5; d0 = 8'h12; v1 = 1'b0;
      cycle();
      v0 = 1'b0;
      cycle();

      // Round-robin with both valid continuously.
      v0 = 1'b1; a0 = 12'h100; d0 = 8'hA0;
      v1 = 1'b1; a1 = 12'h200; d1 = 8'hB1;
      for (int i = 0; i < 6; i++) cycle();

      // Clock enable toggling: nothing moves on disabled cycles.
      for (int i = 0; i < 8; i++) begin
         clk_en = (i % 2 == 0);
         cycle();
      end
      clk_en = 1'b1;

      // Clear started in the same cycle as a req1 request; second pulse at counter 7.
      v0 = 1'b0; v1 = 1'b1; clr_start = 1'b1; clr_dat = 8'h3C;
      cycle();
      clr_start = 1'b0; v0 = 1'b1;
      fill_writes = 0;
      for (int i = 0; i < 20; i++) begin
         clr_start = (i == 7);
         clr_dat   = 8'hC3;
         cycle();
      end
      clr_start = 1'b0;
      chk("clear_word_count", 32'(fill_writes), CLR_EN ? 32'(FW) : 32'd0);

      // Reset while the clear counter sits at 9 aborts the fill.
      v0 = 1'b0; v1 = 1'b0; clr_start = 1'b1; clr_dat = 8'h77;
      cycle();
      clr_start = 1'b0;
      for (int i = 0; i < 9; i++) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) cycle();

      // Random traffic, enables, clears and occasional resets.
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 49) == 0);
         clk_en    = ($urandom_range(0, 9) < 8);
         clr_start = ($urandom_range(0, 39) == 0);
         clr_dat   = MDW'($urandom);
         v0 = ($urandom_range(0, 2) != 0); a0 = MAW'($urandom); d0 = MDW'($urandom);
         v1 = ($urandom_range(0, 2) != 0); a1 = MAW'($urandom); d1 = MDW'($urandom);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
